// File: rtl/alu_input_sequencer.sv
// -----------------------------------------------------------------------------
// alu_input_sequencer
//
// Front-end control for the registered ALU datapath. Two raw pushbuttons
// (enter, undo) are synchronised, debounced and edge-detected, then drive a
// small step machine that walks the operator through A -> B -> OpCode ->
// result. The machine issues one-cycle load strobes to the datapath and shows
// the current step on four one-hot LEDs.
//
// Handshake: there is no valid/ready pair here. Each strobe output is a
// single-cycle pulse that the datapath must act on in that same cycle; at most
// one strobe is high in any cycle.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high; clears all state
//   btn_enter   in   raw pushbutton, asynchronous, high = pressed
//   btn_undo    in   raw pushbutton, asynchronous, high = pressed
//   load_A      out  strobe: capture data_in into A
//   load_B      out  strobe: capture data_in into B
//   load_Op     out  strobe: capture data_in[1:0] into OpCode
//   updateRes   out  strobe: capture ALU Result/Flags
//   state_leds  out  one-hot step indicator {RES,OP,B,A}
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before a button level is
//                    accepted (must be >= 2)
// -----------------------------------------------------------------------------
module alu_input_sequencer #(
   parameter int DEBOUNCE_CYCLES = 200000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_enter,
   input  logic       btn_undo,
   output logic       load_A,
   output logic       load_B,
   output logic       load_Op,
   output logic       updateRes,
   output logic [3:0] state_leds
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   // Bit 0 carries the enter path, bit 1 the undo path; both are identical.
   logic [1:0]    sync1_q, sync1_d;
   logic [1:0]    sync2_q, sync2_d;
   logic [1:0]    db_level_q, db_level_d;
   logic [1:0]    db_prev_q, db_prev_d;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [1:0]    press;
   logic          enter_p;
   logic          undo_p;

   // Synchroniser, debounce counter and edge detector for both buttons.
   always_comb begin
      sync1_d    = {btn_undo, btn_enter};
      sync2_d    = sync1_q;
      db_level_d = db_level_q;
      db_prev_d  = db_level_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         // The counter only runs while the synchronised input disagrees with
         // the accepted level; any bounce back to agreement restarts it.
         if (sync2_q[i] != db_level_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               db_level_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         db_level_q <= '0;
         db_prev_q  <= '0;
         cnt_q[0]   <= '0;
         cnt_q[1]   <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         db_level_q <= db_level_d;
         db_prev_q  <= db_prev_d;
         cnt_q[0]   <= cnt_d[0];
         cnt_q[1]   <= cnt_d[1];
      end
   end

   // One-cycle pulse on the debounced rising edge only.
   assign press = db_level_q & ~db_prev_q;

   // Simultaneous presses cancel each other out.
   assign enter_p = press[0] & ~press[1];
   assign undo_p  = press[1] & ~press[0];

   typedef enum logic [2:0] {
      S_A   = 3'd0,
      S_B   = 3'd1,
      S_OP  = 3'd2,
      S_UPD = 3'd3,
      S_RES = 3'd4
   } state_t;

   state_t state_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_A;
         load_A     <= 1'b0;
         load_B     <= 1'b0;
         load_Op    <= 1'b0;
         updateRes  <= 1'b0;
         state_leds <= 4'b0001;
      end else begin
         load_A    <= 1'b0;
         load_B    <= 1'b0;
         load_Op   <= 1'b0;
         updateRes <= 1'b0;
         case (state_q)
            S_A: begin
               if (enter_p) begin
                  load_A     <= 1'b1;
                  state_q    <= S_B;
                  state_leds <= 4'b0010;
               end
            end
            S_B: begin
               if (enter_p) begin
                  load_B     <= 1'b1;
                  state_q    <= S_OP;
                  state_leds <= 4'b0100;
               end else if (undo_p) begin
                  state_q    <= S_A;
                  state_leds <= 4'b0001;
               end
            end
            S_OP: begin
               if (enter_p) begin
                  load_Op    <= 1'b1;
                  state_q    <= S_UPD;
                  state_leds <= 4'b1000;
               end else if (undo_p) begin
                  state_q    <= S_B;
                  state_leds <= 4'b0010;
               end
            end
            S_UPD: begin
               // One cycle after load_Op so the OpCode register has settled
               // before the result is captured. Presses here are dropped.
               updateRes  <= 1'b1;
               state_q    <= S_RES;
               state_leds <= 4'b1000;
            end
            S_RES: begin
               if (enter_p) begin
                  state_q    <= S_A;
                  state_leds <= 4'b0001;
               end else if (undo_p) begin
                  state_q    <= S_OP;
                  state_leds <= 4'b0100;
               end
            end
            default: begin
               state_q    <= S_A;
               state_leds <= 4'b0001;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for alu_input_sequencer with a short debounce window. Button actions
// feed a step-level model that predicts which strobe appears on which cycle;
// predictions are queued and a monitor matches every strobe the DUT shows.
// -----------------------------------------------------------------------------
module tb_alu_input_sequencer;

   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_enter = 1'b0;
   logic       btn_undo = 1'b0;
   logic       load_A, load_B, load_Op, updateRes;
   logic [3:0] state_leds;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // {cycle at which the strobe is sampled, strobe code {updateRes,Op,B,A}}
   logic [35:0] exp_q[$];

   // Model: step 0=A, 1=B, 2=OP, 3=result shown.
   int step = 0;
   int upd_fire = -1;

   alu_input_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_enter  (btn_enter),
      .btn_undo   (btn_undo),
      .load_A     (load_A),
      .load_B     (load_B),
      .load_Op    (load_Op),
      .updateRes  (updateRes),
      .state_leds (state_leds)
   );

   // ---------------- clock / reset block ----------------
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #(200000 * 10);
      $display("FAIL timeout: bench did not finish in time");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   function automatic logic [3:0] leds_of(input int s);
      case (s)
         0: return 4'b0001;
         1: return 4'b0010;
         2: return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   task automatic push_exp(input int fire, input logic [3:0] code);
      exp_q.push_back({32'(fire), code});
   endtask

   task automatic model_enter(input int fire);
      if (fire == upd_fire) return;
      case (step)
         0: begin push_exp(fire, 4'b0001); step = 1; end
         1: begin push_exp(fire, 4'b0010); step = 2; end
         2: begin
            push_exp(fire, 4'b0100);
            push_exp(fire + 1, 4'b1000);
            upd_fire = fire + 1;
            step = 3;
         end
         default: step = 0;
      endcase
   endtask

   task automatic model_undo(input int fire);
      if (fire == upd_fire) return;
      case (step)
         1: step = 0;
         2: step = 1;
         3: step = 2;
         default: step = 0;
      endcase
   endtask

   task automatic model_reset();
      step = 0;
      upd_fire = -1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin : monitor
      logic [3:0]  code;
      logic [35:0] item;
      while (exp_q.size() != 0 && int'(exp_q[0][35:4]) < cyc) begin
         item = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_strobe: expected code %b at cycle %0d, DUT stayed idle",
                  item[3:0], item[35:4]);
      end
      code = {updateRes, load_Op, load_B, load_A};
      if (code != 4'b0000) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: got code %b at cycle %0d, expected none",
                     code, cyc);
         end else begin
            item = exp_q.pop_front();
            if (item != {32'(cyc), code}) begin
               errors++;
               $display("FAIL strobe: got code %b at cycle %0d, expected code %b at cycle %0d",
                        code, cyc, item[3:0], item[35:4]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_leds(input string name);
      checks++;
      if (state_leds !== leds_of(step)) begin
         errors++;
         $display("FAIL %s: state_leds got %b expected %b", name, state_leds, leds_of(step));
      end
   endtask

   task automatic settle();
      repeat ($urandom_range(D + 5, D + 10)) @(negedge clock);
   endtask

   // kind: 0 enter, 1 undo, 2 both on the same edge, 3 enter then undo a cycle later
   task automatic do_op(input int kind, input int hold, input string name);
      int fire;
      fire = cyc + D + 3;
      case (kind)
         0: model_enter(fire);
         1: model_undo(fire);
         3: begin model_enter(fire); model_undo(fire + 1); end
         default: ;
      endcase
      if (kind != 1) btn_enter = 1'b1;
      if (kind == 1 || kind == 2) btn_undo = 1'b1;
      @(negedge clock);
      if (kind == 3) btn_undo = 1'b1;
      repeat (hold - 1) @(negedge clock);
      btn_enter = 1'b0;
      if (kind != 3) btn_undo = 1'b0;
      @(negedge clock);
      btn_undo = 1'b0;
      settle();
      check_leds(name);
   endtask

   task automatic pulse_reset(input int n);
      reset = 1'b1;
      model_reset();
      repeat (n) @(negedge clock);
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit pat [7];
      int fire;
      int r;
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset held with buttons low.
      repeat (20) begin
         @(negedge clock);
         checks++;
         if ({updateRes, load_Op, load_B, load_A, state_leds} !== 8'b0000_0001) begin
            errors++;
            $display("FAIL reset_state: strobes %b leds %b expected strobes 0000 leds 0001",
                     {updateRes, load_Op, load_B, load_A}, state_leds);
         end
      end
      reset = 1'b0;
      @(negedge clock);

      // Clean enter press held 12 cycles.
      do_op(0, 12, "clean_enter");

      // Bouncing enter, then stable.
      pulse_reset(2);
      @(negedge clock);
      for (int i = 0; i < 7; i++) begin
         btn_enter = pat[i];
         @(negedge clock);
      end
      fire = cyc + D + 3;
      model_enter(fire);
      btn_enter = 1'b1;
      repeat (10) @(negedge clock);
      btn_enter = 1'b0;
      settle();
      check_leds("bounce_enter");

      // Through OpCode to result, then back to A.
      do_op(0, D + 2, "enter_b");
      do_op(0, D + 3, "enter_op_res");
      do_op(0, D + 4, "enter_wrap");

      // Undo chain from S_OP.
      do_op(0, D + 2, "to_b");
      do_op(0, D + 2, "to_op");
      do_op(1, D + 2, "undo_op_b");
      do_op(1, D + 3, "undo_b_a");
      do_op(1, D + 4, "undo_a_a");

      // Simultaneous presses ignored; undo during S_UPD dropped.
      do_op(2, D + 3, "both_a");
      do_op(0, D + 2, "to_b2");
      do_op(2, D + 2, "both_b");
      do_op(0, D + 2, "to_op2");
      do_op(3, D + 3, "undo_in_upd");

      // Reset pulsed while the enter counter is at 2.
      do_op(0, D + 2, "res_to_a");
      btn_enter = 1'b1;
      repeat (4) @(negedge clock);
      btn_enter = 1'b0;
      pulse_reset(2);
      settle();
      check_leds("reset_mid_debounce");

      // Enter held across reset release counts as a new press.
      btn_enter = 1'b1;
      pulse_reset(2);
      model_enter(cyc + D + 3);
      repeat (D + 4) @(negedge clock);
      btn_enter = 1'b0;
      settle();
      check_leds("held_across_reset");

      // Randomised operator activity.
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 4)      do_op(0, $urandom_range(D + 2, D + 8), "rand_enter");
         else if (r <= 7) do_op(1, $urandom_range(D + 2, D + 8), "rand_undo");
         else if (r == 8) do_op(2, $urandom_range(D + 2, D + 8), "rand_both");
         else             do_op(3, $urandom_range(D + 2, D + 8), "rand_enter_undo");
      end

      repeat (20) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected strobes outstanding, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
